// File: rtl/store_commit_queue_pkg.sv
// ---------------------------------------------------------------------------
// store_commit_queue_pkg
//
// Shared parameters for the store commit queue slice: data/address width,
// reorder-buffer index width, the all-zero NULL word, and the state
// encoding of the memory write port FSM.
// ---------------------------------------------------------------------------
package store_commit_queue_pkg;

    // Data and address width of the memory path.
    localparam int WORD_SIZE = 32;

    // Width of a reorder-buffer index.
    localparam int RB_INDEX = 4;

    // Idle value driven on the memory address/data buses.
    localparam logic [WORD_SIZE-1:0] NULL = '0;

    // Memory write port FSM: IDLE waits for a committed entry, WRITE holds
    // the request stable until the memory acknowledges it.
    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_WRITE = 1'b1
    } wr_state_e;

endpackage : store_commit_queue_pkg

// File: rtl/store_commit_queue_if.sv
// ---------------------------------------------------------------------------
// store_commit_queue_if
//
// Bundles the store capture, commit, flush and memory write signals of the
// store commit queue.
//   slave  : the queue itself (captures stores, issues memory writes)
//   master : the pipeline/memory side (issues stores and commits, acks writes)
//
// Signal summary (direction seen from the queue):
//   st_valid/st_addr/st_data/st_rb  in   store from the store RS
//   st_ready                        out  queue can take a store this cycle
//   commit_valid/commit_rb          in   ROB head store retiring
//   flush                           in   mispredict flush
//   mem_we/mem_addr/mem_wdata       out  registered memory write request
//   mem_ack                         in   memory accepted the write
//   empty                           out  no valid entries
//   commit_err                      out  1-cycle pulse on an unmatched commit
// ---------------------------------------------------------------------------
interface store_commit_queue_if #(
    parameter int WORD_SIZE = store_commit_queue_pkg::WORD_SIZE,
    parameter int RB_INDEX  = store_commit_queue_pkg::RB_INDEX
);

    logic                 st_valid;
    logic [WORD_SIZE-1:0] st_addr;
    logic [WORD_SIZE-1:0] st_data;
    logic [RB_INDEX-1:0]  st_rb;
    logic                 st_ready;

    logic                 commit_valid;
    logic [RB_INDEX-1:0]  commit_rb;
    logic                 flush;

    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_ack;

    logic                 empty;
    logic                 commit_err;

    modport slave (
        input  st_valid, st_addr, st_data, st_rb,
        input  commit_valid, commit_rb, flush,
        input  mem_ack,
        output st_ready, mem_we, mem_addr, mem_wdata, empty, commit_err
    );

    modport master (
        output st_valid, st_addr, st_data, st_rb,
        output commit_valid, commit_rb, flush,
        output mem_ack,
        input  st_ready, mem_we, mem_addr, mem_wdata, empty, commit_err
    );

endinterface : store_commit_queue_if

// File: rtl/store_commit_queue_mem_write_port.sv
// ---------------------------------------------------------------------------
// mem_write_port
//
// Two-state write FSM that drains committed stores to memory, one at a time.
//   IDLE  -> WRITE : a committed entry is pending; the request registers are
//                    loaded from the head entry and mem_we rises on this edge.
//   WRITE -> IDLE  : mem_ack sampled high; mem_we clears and pop pulses so the
//                    queue advances its head pointer.
// After every write the FSM spends at least one cycle in IDLE, so
// consecutive writes are always separated by a low mem_we cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pending             head != cmt (a committed entry waits to be written)
//   wr_addr, wr_data    payload of the head entry
//   mem_ack             memory accepted the write on this edge
//   mem_we/mem_addr/mem_wdata  registered write request
//   pop                 head entry retired this edge (combinational)
// ---------------------------------------------------------------------------
module mem_write_port #(
    parameter int WORD_SIZE = store_commit_queue_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pending,
    input  logic [WORD_SIZE-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 mem_ack,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 pop
);

    import store_commit_queue_pkg::*;

    wr_state_e state;

    // The head entry retires on the edge that samples mem_ack in WRITE;
    // an ack seen in IDLE is ignored.
    assign pop = (state == WR_WRITE) && mem_ack;

    // NOTE: every register in a clocked block is assigned with <= so all
    // flops see the pre-edge values of each other, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // A reset during WRITE abandons the request outright.
            state     <= WR_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= WORD_SIZE'(NULL);
            mem_wdata <= WORD_SIZE'(NULL);
        end else begin
            case (state)
                WR_IDLE: begin
                    if (pending) begin
                        mem_addr  <= wr_addr;
                        mem_wdata <= wr_data;
                        mem_we    <= 1'b1;
                        state     <= WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    // Request stays frozen until the memory takes it; a flush
                    // upstream never touches these registers.
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        state  <= WR_IDLE;
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= WR_IDLE;
                end
            endcase
        end
    end

endmodule : mem_write_port

// File: rtl/store_commit_queue.sv
// ---------------------------------------------------------------------------
// store_commit_queue
//
// Circular queue holding completed stores between address/data computation
// and memory. Three pointers partition the ring:
//   head .. cmt   committed stores, waiting for (or in) the memory write
//   cmt  .. tail  captured stores not yet retired by the ROB
// A flush throws away the uncommitted region by pulling tail back to cmt.
// Each pointer carries an extra wrap bit so full and empty are
// distinguishable when the index bits match.
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    store_commit_queue_if.slave (store capture, commit, flush,
//          memory write request/ack, empty, commit_err)
//
// DEPTH must be a power of two and at least 2 so that the index wraps
// naturally on pointer overflow.
// ---------------------------------------------------------------------------
module store_commit_queue #(
    parameter int WORD_SIZE = store_commit_queue_pkg::WORD_SIZE,
    parameter int RB_INDEX  = store_commit_queue_pkg::RB_INDEX,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    store_commit_queue_if.slave  bus
);

    import store_commit_queue_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Pointers (wrap bit in the MSB) and their index parts.
    ptr_t             head;
    ptr_t             cmt;
    ptr_t             tail;
    ptr_t             cmt_next;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] cmt_idx;
    logic [IDX_W-1:0] tail_idx;

    // Entry payload.
    logic [RB_INDEX-1:0]  ent_rb   [DEPTH];
    logic [WORD_SIZE-1:0] ent_addr [DEPTH];
    logic [WORD_SIZE-1:0] ent_data [DEPTH];

    logic full;
    logic capture;
    logic commit_match;
    logic commit_ok;
    logic commit_err_q;
    logic pop;

    logic                 wr_we;
    logic [WORD_SIZE-1:0] wr_addr_q;
    logic [WORD_SIZE-1:0] wr_data_q;

    assign head_idx = head[IDX_W-1:0];
    assign cmt_idx  = cmt[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    // Occupancy comes from the registered pointers only, so a pop on this
    // edge frees its slot for the next cycle, not this one.
    assign full = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);

    // A store arriving while full is dropped; one arriving with a flush is
    // discarded because the flush rewinds tail anyway.
    assign capture = bus.st_valid && !full && !bus.flush;

    // The commit must name the oldest uncommitted entry. A store being
    // captured on this same edge is not yet in the ring (cmt == tail or a
    // different rb at cmt), so it cannot be committed early.
    assign commit_match = (cmt != tail) && (ent_rb[cmt_idx] == bus.commit_rb);
    assign commit_ok    = bus.commit_valid && commit_match;

    // Flush keeps everything up to and including a same-cycle commit.
    assign cmt_next = commit_ok ? cmt + PTR_W'(1) : cmt;

    always_ff @(posedge clk) begin
        if (reset) begin
            head         <= '0;
            cmt          <= '0;
            tail         <= '0;
            commit_err_q <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            cmt <= cmt_next;
            if (bus.flush) begin
                tail <= cmt_next;
            end else if (capture) begin
                tail <= tail + PTR_W'(1);
            end
            commit_err_q <= bus.commit_valid && !commit_match;
        end
    end

    // NOTE: payload storage has no reset; the pointers alone decide which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (capture) begin
            ent_rb[tail_idx]   <= bus.st_rb;
            ent_addr[tail_idx] <= bus.st_addr;
            ent_data[tail_idx] <= bus.st_data;
        end
    end

    mem_write_port #(
        .WORD_SIZE (WORD_SIZE)
    ) u_mem_write_port (
        .clk       (clk),
        .reset     (reset),
        .pending   (head != cmt),
        .wr_addr   (ent_addr[head_idx]),
        .wr_data   (ent_data[head_idx]),
        .mem_ack   (bus.mem_ack),
        .mem_we    (wr_we),
        .mem_addr  (wr_addr_q),
        .mem_wdata (wr_data_q),
        .pop       (pop)
    );

    assign bus.mem_we     = wr_we;
    assign bus.mem_addr   = wr_addr_q;
    assign bus.mem_wdata  = wr_data_q;
    assign bus.st_ready   = !full;
    assign bus.empty      = (head == tail);
    assign bus.commit_err = commit_err_q;

endmodule : store_commit_queue

// File: doc/store_commit_queue.md
STORE_COMMIT_QUEUE -- requirements
Module: store_commit_queue

Interface
REQ-001 Parameter WORD_SIZE, default 32, data and address width; taken from the shared parameters include.
REQ-002 Parameter RB_INDEX, default 4, reorder-buffer index width; taken from the shared parameters include.
REQ-003 Parameter DEPTH, default 4, number of queue entries; must be a power of two.
REQ-004 clk  in  1  single clock; every flop is updated on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 st_valid  in  1  1-cycle pulse; a store RS has finished its address/data computation.
REQ-007 st_addr  in  WORD_SIZE  effective address from the store RS addr_bus lane.
REQ-008 st_data  in  WORD_SIZE  store data from the store RS data_bus lane.
REQ-009 st_rb  in  RB_INDEX  ROB index of the store, from the RB_index_bus lane.
REQ-010 st_ready  out  1  high when the queue can capture a store this cycle.
REQ-011 commit_valid  in  1  ROB head is a store that is retiring this cycle.
REQ-012 commit_rb  in  RB_INDEX  ROB index of the retiring store.
REQ-013 flush  in  1  mispredict flush; discards all uncommitted entries.
REQ-014 mem_we  out  1  memory write request, registered.
REQ-015 mem_addr  out  WORD_SIZE  write address, registered.
REQ-016 mem_wdata  out  WORD_SIZE  write data, registered.
REQ-017 mem_ack  in  1  memory accepted the write on this edge.
REQ-018 empty  out  1  no valid entries.
REQ-019 commit_err  out  1  1-cycle pulse for an unmatched commit.

Function
REQ-020 The queue SHALL be circular and use three pointers: head (oldest entry), cmt (first uncommitted entry) and tail (next free slot); the committed entries form the prefix from head to cmt.
REQ-021 Capture: when st_valid and st_ready are both high, the queue SHALL write {st_rb, st_addr, st_data} at tail and increment tail modulo DEPTH.
REQ-022 st_ready SHALL equal NOT full, using the occupancy at the start of the cycle; a pop in the same cycle does not free a slot early.
REQ-023 st_valid while full SHALL be dropped, with no pointer change.
REQ-024 Commit: on commit_valid, if cmt != tail and entry[cmt].rb == commit_rb, cmt SHALL advance by one; otherwise commit_err SHALL pulse high for exactly one cycle and no pointer SHALL change.
REQ-025 A commit naming a store that is being captured in the same cycle SHALL raise commit_err.
REQ-026 Flush: tail SHALL be set to cmt (post-commit value) at the end of the cycle.
- A commit in the same cycle as a flush takes effect first.
- A capture in the same cycle as a flush is discarded.
REQ-027 The write FSM SHALL have two states, IDLE and WRITE.
- IDLE to WRITE: when head != cmt, mem_addr and mem_wdata are loaded from entry[head] and mem_we is set on the next edge.
- WRITE: mem_we, mem_addr and mem_wdata SHALL stay stable until mem_ack is sampled high.
- WRITE to IDLE: on the mem_ack edge, mem_we clears and head increments.
REQ-028 Write latency: mem_we SHALL rise 1 cycle after an entry becomes committed. Back-to-back writes SHALL be separated by at least 1 IDLE cycle.
REQ-029 mem_ack sampled while in IDLE SHALL be ignored.
REQ-030 The write in progress SHALL be unaffected by a flush.
REQ-031 Pointers SHALL carry one extra wrap bit.
- full = equal index bits with differing wrap bits.
- empty = head == tail.

Reset
REQ-032 Reset SHALL give the following values:
- head = cmt = tail = 0; state IDLE.
- mem_we = 0; mem_addr = 0; mem_wdata = 0.
- st_ready = 1; empty = 1; commit_err = 0.
REQ-033 A reset during WRITE SHALL abandon the write; mem_we SHALL be low in the cycle after the reset edge.
REQ-034 Entry payload storage need not be reset.

Structure
REQ-035 WORD_SIZE, RB_INDEX and NULL SHALL come from the shared parameters include; the FSM state encodings SHALL be added to that same include.
REQ-036 The write FSM with its output registers SHALL be one sub-module, mem_write_port; pointer and entry logic SHALL stay in store_commit_queue.

Verification
REQ-037 Basic store: capture rb=3, addr=0x40, data=0xDEAD; commit rb=3; mem_ack 2 cycles after mem_we -> mem_we rises 1 cycle after the commit with 0x40/0xDEAD and stays high for 3 cycles; empty=1 afterwards.
REQ-038 Full queue: capture 4 stores with mem_ack held low -> st_ready=0; a 5th st_valid is dropped; after commit plus ack of the head, st_ready=1 one cycle later.
REQ-039 Bad commit: capture rb=1 and rb=2, then commit rb=2 first -> commit_err pulses for 1 cycle; no write occurs; a later commit of rb=1 is accepted.
REQ-040 Flush: capture rb=1, 2, 3; commit rb=1; flush -> exactly one write (rb=1 data) is issued; empty=1 after its ack; tail == head.
REQ-041 Simultaneous events: in one cycle apply commit rb=5, flush, and a capture of rb=6 -> rb=5 is written; rb=6 is absent; commit_err=0.
REQ-042 Reset in WRITE: assert reset while mem_we=1 -> mem_we=0, empty=1 and st_ready=1 on the next cycle; a later mem_ack is ignored.
